// File: rtl/input_scheduler.sv
// Input scheduler: synchronises raw key lines, applies DAS/auto-repeat and
// priority arbitration, and offers one-shot commands to the game over valid/ready.
module input_scheduler #(
  parameter int unsigned DAS_TICKS  = 10,
  parameter int unsigned ARR_TICKS  = 2,
  parameter int unsigned SOFT_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_game,
  input  logic       enable,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_down,
  input  logic       key_rotate,
  input  logic       key_drop,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code
);
  localparam int unsigned NKEY   = 5;
  localparam int unsigned NRPT   = 3;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned CODE_W = 3;

  // Key bit index = command code - 1; the first three also index the repeat channels.
  localparam int unsigned K_LEFT  = 0;
  localparam int unsigned K_RIGHT = 1;
  localparam int unsigned K_DOWN  = 2;
  localparam int unsigned K_ROT   = 3;
  localparam int unsigned K_DROP  = 4;

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  DAS_T     = CNT_W'(DAS_TICKS);
  localparam logic [CNT_W-1:0]  ARR_T     = CNT_W'(ARR_TICKS);
  localparam logic [CNT_W-1:0]  SOFT_T    = CNT_W'(SOFT_TICKS);
  localparam logic [NKEY-1:0]   DROP_MASK = 5'b10000;
  localparam logic [CODE_W-1:0] CODE_NONE  = 3'd0;
  localparam logic [CODE_W-1:0] CODE_LEFT  = 3'd1;
  localparam logic [CODE_W-1:0] CODE_RIGHT = 3'd2;
  localparam logic [CODE_W-1:0] CODE_DOWN  = 3'd3;
  localparam logic [CODE_W-1:0] CODE_ROT   = 3'd4;
  localparam logic [CODE_W-1:0] CODE_DROP  = 3'd5;

  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_e;
  typedef enum logic [1:0] {ACT_NONE, ACT_LEFT, ACT_RIGHT} act_e;

  logic [NKEY-1:0]   keys_raw, s1_q, s2_q, s2p_q, press, req;
  logic [NRPT-1:0]   start, run;
  act_e              act_q, act_d;
  rpt_state_e        st_q [NRPT];
  rpt_state_e        st_d [NRPT];
  logic [CNT_W-1:0]  cnt_q [NRPT];
  logic [CNT_W-1:0]  cnt_d [NRPT];
  logic [NKEY-1:0]   pend_q, pend_d, cand, win;
  logic              valid_q, valid_d, drop_acc, load;
  logic [CODE_W-1:0] code_q, code_d, code_w;

  assign keys_raw  = {key_drop, key_rotate, key_down, key_right, key_left};
  assign cmd_valid = valid_q;
  assign cmd_code  = code_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s2p_q   <= '0;
      act_q   <= ACT_NONE;
      for (int unsigned i = 0; i < NRPT; i++) begin
        st_q[i]  <= RPT_IDLE;
        cnt_q[i] <= '0;
      end
      pend_q  <= '0;
      valid_q <= 1'b0;
      code_q  <= CODE_NONE;
    end else begin
      s1_q    <= keys_raw;
      s2_q    <= s1_q;
      s2p_q   <= s2_q;
      act_q   <= act_d;
      for (int unsigned i = 0; i < NRPT; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      pend_q  <= pend_d;
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  // Left/right ownership: newest press wins, release hands over with a synthetic press.
  always_comb begin
    act_d = act_q;
    start = '0;
    press = s2_q & ~s2p_q & {NKEY{enable}};
    if (!enable) begin
      act_d = ACT_NONE;
    end else if (press[K_RIGHT]) begin
      act_d          = ACT_RIGHT;
      start[K_RIGHT] = 1'b1;
    end else if (press[K_LEFT]) begin
      act_d         = ACT_LEFT;
      start[K_LEFT] = 1'b1;
    end else if (act_q == ACT_LEFT && !s2_q[K_LEFT]) begin
      act_d = ACT_NONE;
      if (s2_q[K_RIGHT]) begin
        act_d          = ACT_RIGHT;
        start[K_RIGHT] = 1'b1;
      end
    end else if (act_q == ACT_RIGHT && !s2_q[K_RIGHT]) begin
      act_d = ACT_NONE;
      if (s2_q[K_LEFT]) begin
        act_d         = ACT_LEFT;
        start[K_LEFT] = 1'b1;
      end
    end
    start[K_DOWN] = press[K_DOWN];
    run[K_LEFT]   = (act_d == ACT_LEFT);
    run[K_RIGHT]  = (act_d == ACT_RIGHT);
    run[K_DOWN]   = enable & s2_q[K_DOWN];
  end

  // Repeat FSMs; down stays in DELAY and repeats at the soft-drop rate.
  always_comb begin
    logic [CNT_W-1:0] inc;
    logic [CNT_W-1:0] tgt;
    req = '0;
    for (int unsigned i = 0; i < NRPT; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      inc      = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
      if (st_q[i] == RPT_REPEAT) tgt = ARR_T;
      else if (i == K_DOWN)      tgt = SOFT_T;
      else                       tgt = DAS_T;
      if (start[i]) begin
        st_d[i]  = RPT_DELAY;
        cnt_d[i] = '0;
        req[i]   = 1'b1;
      end else if (!run[i] || st_q[i] == RPT_IDLE) begin
        st_d[i]  = RPT_IDLE;
        cnt_d[i] = '0;
      end else if (tick_game) begin
        if (inc == tgt) begin
          req[i]   = 1'b1;
          cnt_d[i] = '0;
          st_d[i]  = (i == K_DOWN) ? RPT_DELAY : RPT_REPEAT;
        end else begin
          cnt_d[i] = inc;
        end
      end
    end
    req[K_ROT]  = press[K_ROT];
    req[K_DROP] = press[K_DROP];
  end

  // Pending set, priority pick and output register with hold under backpressure.
  always_comb begin
    drop_acc = valid_q & cmd_ready & (code_q == CODE_DROP);
    load     = ~valid_q | cmd_ready;
    cand     = drop_acc ? (pend_q & DROP_MASK) : pend_q;
    win      = '0;
    code_w   = CODE_NONE;
    if (cand[K_DROP]) begin
      win[K_DROP] = 1'b1;
      code_w      = CODE_DROP;
    end else if (cand[K_ROT]) begin
      win[K_ROT] = 1'b1;
      code_w     = CODE_ROT;
    end else if (cand[K_LEFT]) begin
      win[K_LEFT] = 1'b1;
      code_w      = CODE_LEFT;
    end else if (cand[K_RIGHT]) begin
      win[K_RIGHT] = 1'b1;
      code_w       = CODE_RIGHT;
    end else if (cand[K_DOWN]) begin
      win[K_DOWN] = 1'b1;
      code_w      = CODE_DOWN;
    end
    pend_d  = pend_q;
    valid_d = valid_q;
    code_d  = code_q;
    if (!enable) begin
      pend_d  = '0;
      valid_d = 1'b0;
      code_d  = CODE_NONE;
    end else begin
      if (load) begin
        valid_d = |cand;
        code_d  = code_w;
        pend_d  = pend_q & ~win;
      end
      pend_d = pend_d | req;
      if (drop_acc) pend_d = pend_d & DROP_MASK;
    end
  end
endmodule

// File: tb/tb_input_scheduler.sv
// Bench for input_scheduler: directed scenarios plus randomized traffic, all
// compared cycle by cycle against an elapsed-tick reference model.
module tb_input_scheduler;
  localparam int DAS  = 10;
  localparam int ARR  = 2;
  localparam int SOFT = 3;

  logic       clk = 1'b0;
  logic       rst, tick_game, enable, cmd_ready;
  logic       key_left, key_right, key_down, key_rotate, key_drop;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  int errors = 0;
  int checks = 0;

  input_scheduler #(.DAS_TICKS(DAS), .ARR_TICKS(ARR), .SOFT_TICKS(SOFT)) dut (
    .clk(clk), .rst(rst), .tick_game(tick_game), .enable(enable),
    .key_left(key_left), .key_right(key_right), .key_down(key_down),
    .key_rotate(key_rotate), .key_drop(key_drop),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_code(cmd_code)
  );

  always #5 clk = ~clk;

  // Reference model: key index = code-1; el[] = ticks elapsed since the key's
  // (re)start, -1 when it is not running; m_act 0=none 1=left 2=right.
  logic [4:0] m_s1 = '0, m_s2 = '0, m_s2p = '0, m_pend = '0;
  logic       m_valid = 1'b0;
  int         m_code = 0;
  int         m_act = 0;
  int         m_el[3] = '{-1, -1, -1};
  int         prio[5] = '{4, 3, 0, 1, 2};

  always @(posedge clk) begin : model
    logic [4:0] keys, prs, rq, avail;
    logic       st_l, st_r, acc, dacc, got;
    int         nact;
    keys = {key_drop, key_rotate, key_down, key_right, key_left};
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_s2p = '0; m_pend = '0;
      m_valid = 1'b0; m_code = 0; m_act = 0;
      m_el = '{-1, -1, -1};
    end else begin
      prs  = enable ? (m_s2 & ~m_s2p) : 5'b0;
      rq   = '0;
      st_l = 1'b0;
      st_r = 1'b0;
      nact = m_act;
      if (!enable) nact = 0;
      else if (prs[1]) begin nact = 2; st_r = 1'b1; end
      else if (prs[0]) begin nact = 1; st_l = 1'b1; end
      else if (m_act == 1 && !m_s2[0]) begin
        nact = 0;
        if (m_s2[1]) begin nact = 2; st_r = 1'b1; end
      end else if (m_act == 2 && !m_s2[1]) begin
        nact = 0;
        if (m_s2[0]) begin nact = 1; st_l = 1'b1; end
      end
      for (int k = 0; k < 2; k++) begin
        if ((k == 0) ? st_l : st_r) begin
          m_el[k] = 0;
          rq[k] = 1'b1;
        end else if (nact != k + 1) begin
          m_el[k] = -1;
        end else if (tick_game) begin
          m_el[k]++;
          if (m_el[k] == DAS || (m_el[k] > DAS && (m_el[k] - DAS) % ARR == 0)) rq[k] = 1'b1;
        end
      end
      if (!enable || !m_s2[2]) m_el[2] = -1;
      else if (prs[2]) begin m_el[2] = 0; rq[2] = 1'b1; end
      else if (m_el[2] >= 0 && tick_game) begin
        m_el[2]++;
        if (m_el[2] % SOFT == 0) rq[2] = 1'b1;
      end
      rq[3] = prs[3];
      rq[4] = prs[4];
      m_act = nact;
      acc  = m_valid && cmd_ready;
      dacc = acc && m_code == 5;
      if (!enable) begin
        m_valid = 1'b0; m_code = 0; m_pend = '0;
      end else begin
        avail = dacc ? (m_pend & 5'b10000) : m_pend;
        if (!m_valid || acc) begin
          got = 1'b0;
          m_code = 0;
          for (int j = 0; j < 5; j++) begin
            if (!got && avail[prio[j]]) begin
              got = 1'b1;
              m_code = prio[j] + 1;
              m_pend[prio[j]] = 1'b0;
            end
          end
          m_valid = got;
        end
        m_pend = m_pend | rq;
        if (dacc) m_pend = m_pend & 5'b10000;
      end
      m_s2p = m_s2;
      m_s2  = m_s1;
      m_s1  = keys;
    end
  end

  task automatic cyc(input logic tk);
    tick_game = tk;
    @(posedge clk);
    @(negedge clk);
    tick_game = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(1'b1);
    cyc(1'b0);
    checks++;
    if (cmd_valid !== 1'b0 || cmd_code !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b code=%0d, want valid=0 code=0", cmd_valid, cmd_code);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0);
      checks++;
      if (cmd_valid !== m_valid || cmd_code !== 3'(m_code)) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got v=%b c=%0d want v=%b c=%0d", i, cmd_valid, cmd_code, m_valid, m_code);
      end
    end
  endtask

  task automatic test_single_press;
    int nv = 0;
    int first = -1;
    logic [2:0] fcode = 3'd0;
    cmd_ready  = 1'b1;
    key_rotate = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) key_rotate = 1'b0;
      cyc(1'b0);
      checks++;
      if (cmd_valid !== m_valid || cmd_code !== 3'(m_code)) begin
        errors++;
        $display("FAIL single_press_model cyc %0d: got v=%b c=%0d want v=%b c=%0d", i, cmd_valid, cmd_code, m_valid, m_code);
      end
      if (cmd_valid === 1'b1) begin
        nv++;
        if (first < 0) begin first = i; fcode = cmd_code; end
      end
    end
    checks++;
    if (nv != 1 || first != 3 || fcode !== 3'd4) begin
      errors++;
      $display("FAIL single_press: got %0d valid cycles first at edge %0d code %0d, want 1 at edge 3 code 4", nv, first, fcode);
    end
  endtask

  task automatic test_left_das;
    int nleft = 0;
    int nother = 0;
    cmd_ready = 1'b1;
    key_left  = 1'b1;
    for (int i = 0; i < 96; i++) begin
      if (i == 81) key_left = 1'b0;
      if (cmd_valid === 1'b1 && cmd_code === 3'd1) nleft++;
      else if (cmd_valid === 1'b1) nother++;
      cyc(i >= 4 && i <= 80 && i % 4 == 0);
      checks++;
      if (cmd_valid !== m_valid || cmd_code !== 3'(m_code)) begin
        errors++;
        $display("FAIL left_das_model cyc %0d: got v=%b c=%0d want v=%b c=%0d", i, cmd_valid, cmd_code, m_valid, m_code);
      end
    end
    checks++;
    if (nleft != 7 || nother != 0) begin
      errors++;
      $display("FAIL left_das_count: got %0d LEFT and %0d other, want 7 LEFT and 0 other", nleft, nother);
    end
  endtask

  task automatic test_backpressure;
    int acc[$];
    cmd_ready = 1'b0;
    key_down  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) key_down = 1'b0;
      cyc(1'b0);
      checks++;
      if (cmd_valid !== m_valid || cmd_code !== 3'(m_code)) begin
        errors++;
        $display("FAIL bp_model cyc %0d: got v=%b c=%0d want v=%b c=%0d", i, cmd_valid, cmd_code, m_valid, m_code);
      end
    end
    key_drop   = 1'b1;
    key_rotate = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin key_drop = 1'b0; key_rotate = 1'b0; end
      cyc(1'b0);
      checks++;
      if (cmd_valid !== 1'b1 || cmd_code !== 3'd3) begin
        errors++;
        $display("FAIL bp_hold cyc %0d: got v=%b c=%0d want v=1 c=3", i, cmd_valid, cmd_code);
      end
    end
    cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (cmd_valid === 1'b1) acc.push_back(int'(cmd_code));
      cyc(1'b0);
      checks++;
      if (cmd_valid !== m_valid || cmd_code !== 3'(m_code)) begin
        errors++;
        $display("FAIL bp_release_model cyc %0d: got v=%b c=%0d want v=%b c=%0d", i, cmd_valid, cmd_code, m_valid, m_code);
      end
    end
    checks++;
    if (acc.size() != 2 || acc[0] != 3 || acc[1] != 5) begin
      errors++;
      $display("FAIL bp_sequence: got %0d accepted %p, want DOWN then DROP only", acc.size(), acc);
    end
  endtask

  task automatic test_conflict;
    int codes[$];
    int at[$];
    int ticks = 0;
    logic tk;
    cmd_ready = 1'b1;
    key_left  = 1'b1;
    for (int i = 0; i < 90; i++) begin
      if (i == 17) key_right = 1'b1;
      if (i == 33) key_right = 1'b0;
      if (i == 77) key_left  = 1'b0;
      if (cmd_valid === 1'b1) begin codes.push_back(int'(cmd_code)); at.push_back(ticks); end
      tk = (i > 0 && i % 4 == 0);
      cyc(tk);
      if (tk) ticks++;
      checks++;
      if (cmd_valid !== m_valid || cmd_code !== 3'(m_code)) begin
        errors++;
        $display("FAIL conflict_model cyc %0d: got v=%b c=%0d want v=%b c=%0d", i, cmd_valid, cmd_code, m_valid, m_code);
      end
    end
    checks++;
    if (codes.size() != 4 || codes[0] != 1 || codes[1] != 2 || codes[2] != 1 || codes[3] != 1) begin
      errors++;
      $display("FAIL conflict_sequence: got %p, want LEFT RIGHT LEFT LEFT", codes);
    end else begin
      checks++;
      if (at[1] > 5 || at[2] < 8 || at[2] > 9 || at[3] != 18) begin
        errors++;
        $display("FAIL conflict_timing: got ticks %p, want RIGHT by 5, LEFT at 8-9, LEFT at 18", at);
      end
    end
  endtask

  task automatic test_disable_reset;
    int first = -1;
    logic [2:0] fcode = 3'd0;
    cmd_ready = 1'b0;
    key_down  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(i % 4 == 3);
      checks++;
      if (cmd_valid !== m_valid || cmd_code !== 3'(m_code)) begin
        errors++;
        $display("FAIL dis_model cyc %0d: got v=%b c=%0d want v=%b c=%0d", i, cmd_valid, cmd_code, m_valid, m_code);
      end
    end
    checks++;
    if (cmd_valid !== 1'b1 || cmd_code !== 3'd3) begin
      errors++;
      $display("FAIL dis_pending: got v=%b c=%0d want v=1 c=3", cmd_valid, cmd_code);
    end
    enable = 1'b0;
    cyc(1'b0);
    checks++;
    if (cmd_valid !== 1'b0 || cmd_code !== 3'd0) begin
      errors++;
      $display("FAIL dis_clear: got v=%b c=%0d want v=0 c=0", cmd_valid, cmd_code);
    end
    for (int i = 0; i < 16; i++) begin
      key_rotate = (i < 3);
      cyc(i % 4 == 3);
      checks++;
      if (cmd_valid !== 1'b0 || cmd_code !== 3'd0) begin
        errors++;
        $display("FAIL dis_quiet cyc %0d: got v=%b c=%0d want v=0 c=0", i, cmd_valid, cmd_code);
      end
    end
    enable    = 1'b1;
    cmd_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cyc(i % 4 == 3);
      checks++;
      if (cmd_valid !== 1'b0 || cmd_valid !== m_valid) begin
        errors++;
        $display("FAIL en_rise_held cyc %0d: got v=%b c=%0d want v=0", i, cmd_valid, cmd_code);
      end
    end
    rst = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0);
      checks++;
      if (cmd_valid !== m_valid || cmd_code !== 3'(m_code)) begin
        errors++;
        $display("FAIL rst_held_model cyc %0d: got v=%b c=%0d want v=%b c=%0d", i, cmd_valid, cmd_code, m_valid, m_code);
      end
      if (cmd_valid === 1'b1 && first < 0) begin first = i; fcode = cmd_code; end
    end
    checks++;
    if (first != 3 || fcode !== 3'd3) begin
      errors++;
      $display("FAIL rst_held_down: got first valid at edge %0d code %0d, want edge 3 code 3", first, fcode);
    end
    key_down = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) key_left   = ~key_left;
      if ($urandom_range(0, 39) == 0) key_right  = ~key_right;
      if ($urandom_range(0, 29) == 0) key_down   = ~key_down;
      if ($urandom_range(0, 11) == 0) key_rotate = ~key_rotate;
      if ($urandom_range(0, 15) == 0) key_drop   = ~key_drop;
      cmd_ready = ($urandom_range(0, 3) != 0);
      if (enable && $urandom_range(0, 149) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
      rst = ($urandom_range(0, 499) == 0);
      cyc($urandom_range(0, 2) == 0);
      checks++;
      if (cmd_valid !== m_valid || cmd_code !== 3'(m_code)) begin
        errors++;
        $display("FAIL random_model cyc %0d: got v=%b c=%0d want v=%b c=%0d", i, cmd_valid, cmd_code, m_valid, m_code);
      end
    end
    rst = 1'b0;
    enable = 1'b1;
    {key_left, key_right, key_down, key_rotate, key_drop} = '0;
  endtask

  initial begin
    rst = 1'b1; tick_game = 1'b0; enable = 1'b1; cmd_ready = 1'b1;
    key_left = 1'b0; key_right = 1'b0; key_down = 1'b0; key_rotate = 1'b0; key_drop = 1'b0;
    test_reset();
    test_single_press();
    test_left_das();
    test_backpressure();
    test_conflict();
    test_disable_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
